instr_sequencer: RTL and testbench

Multi-cycle control sequencer for the 16-bit Harvard core. It fetches 32-bit instruction words from instruction memory and splits them into opcode and fields. It then steps the register file, ALU, multiplier and data memory through each instruction, one instruction at a time. It replaces the free-running combinational decode with a clocked FSM that owns the PC and every write-enable in the datapath.

---
 rtl/instr_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/execute sequencer for the 16-bit Harvard core
// Owns the PC and every datapath strobe; one instruction in flight at a time.
module instr_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [4:0]      rf_ra1,
    output logic [4:0]      rf_ra2,
    input  logic [15:0]     rf_rd1,
    input  logic [15:0]     rf_rd2,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [15:0]     rf_wd,
    output logic [4:0]      alu_op,
    output logic [15:0]     alu_a,
    output logic [15:0]     alu_b,
    input  logic [15:0]     alu_y,
    input  logic [15:0]     alu_hi,
    output logic            mul_start,
    input  logic            mul_done,
    input  logic [15:0]     mul_lo,
    input  logic [15:0]     mul_hi,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [7:0]      dmem_addr,
    output logic [15:0]     dmem_wdata,
    input  logic [15:0]     dmem_rdata,
    input  logic            dmem_ack,
    output logic            illegal,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MULW,
        S_MEM,
        S_WB1,
        S_WB2
    } state_t;

    localparam logic [5:0] OP_IMM   = 6'h00;
    localparam logic [5:0] OP_MOV   = 6'h01;
    localparam logic [5:0] OP_LOAD  = 6'h02;
    localparam logic [5:0] OP_STORE = 6'h03;
    localparam logic [5:0] OP_ADD   = 6'h04;
    localparam logic [5:0] OP_SUB   = 6'h05;
    localparam logic [5:0] OP_MUL   = 6'h07;
    localparam logic [5:0] OP_LAST  = 6'h10;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     instr_q;
    logic [15:0]     opa_q;
    logic [15:0]     opb_q;
    logic [15:0]     hi_q;
    logic            imem_req_q;
    logic            rf_we_q;
    logic [4:0]      rf_wa_q;
    logic [15:0]     rf_wd_q;
    logic            mul_start_q;
    logic            dmem_req_q;
    logic            dmem_we_q;
    logic [7:0]      dmem_addr_q;
    logic            illegal_q;
    logic            busy_q;

    logic [5:0]      opcode;
    logic [4:0]      rdst1;
    logic [4:0]      rdst2;
    logic [PC_W-1:0] pc_d;
    logic            two_write;

    assign opcode    = instr_q[31:26];
    assign rdst2     = instr_q[25:21];
    assign rdst1     = instr_q[20:16];
    assign pc_d      = pc_q + PC_W'(1);
    assign two_write = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_MUL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            instr_q     <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            hi_q        <= '0;
            imem_req_q  <= 1'b1;
            rf_we_q     <= 1'b0;
            rf_wa_q     <= '0;
            rf_wd_q     <= '0;
            mul_start_q <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            dmem_addr_q <= '0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rf_we_q     <= 1'b0;
            mul_start_q <= 1'b0;
            illegal_q   <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q    <= imem_data;
                        imem_req_q <= 1'b0;
                        busy_q     <= 1'b1;
                        // flag the undefined opcode now so the pulse lands in DECODE
                        illegal_q  <= (imem_data[31:26] > OP_LAST);
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opa_q       <= rf_rd1;
                    opb_q       <= rf_rd2;
                    dmem_addr_q <= (opcode == OP_STORE) ? instr_q[25:18] : instr_q[7:0];
                    if (opcode > OP_LAST) begin
                        pc_q       <= pc_d;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_FETCH;
                    end else begin
                        mul_start_q <= (opcode == OP_MUL);
                        state_q     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_IMM: begin
                            rf_wd_q <= instr_q[15:0];
                            rf_wa_q <= rdst2;
                            rf_we_q <= 1'b1;
                            state_q <= S_WB1;
                        end
                        OP_MOV: begin
                            rf_wd_q <= opb_q;
                            rf_wa_q <= rdst2;
                            rf_we_q <= 1'b1;
                            state_q <= S_WB1;
                        end
                        OP_LOAD, OP_STORE: begin
                            dmem_req_q <= 1'b1;
                            dmem_we_q  <= (opcode == OP_STORE);
                            state_q    <= S_MEM;
                        end
                        OP_MUL: begin
                            state_q <= S_MULW;
                        end
                        default: begin
                            rf_wd_q <= alu_y;
                            hi_q    <= alu_hi;
                            rf_wa_q <= rdst1;
                            rf_we_q <= 1'b1;
                            state_q <= S_WB1;
                        end
                    endcase
                end
                S_MULW: begin
                    if (mul_done) begin
                        rf_wd_q <= mul_lo;
                        hi_q    <= mul_hi;
                        rf_wa_q <= rdst1;
                        rf_we_q <= 1'b1;
                        state_q <= S_WB1;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (dmem_we_q) begin
                            pc_q       <= pc_d;
                            imem_req_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_FETCH;
                        end else begin
                            rf_wd_q <= dmem_rdata;
                            rf_wa_q <= rdst2;
                            rf_we_q <= 1'b1;
                            state_q <= S_WB1;
                        end
                    end
                end
                S_WB1: begin
                    // second write goes last so that hi wins when both destinations match
                    if (two_write) begin
                        rf_wd_q <= hi_q;
                        rf_wa_q <= rdst2;
                        rf_we_q <= 1'b1;
                        state_q <= S_WB2;
                    end else begin
                        pc_q       <= pc_d;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                S_WB2: begin
                    pc_q       <= pc_d;
                    imem_req_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_FETCH;
                end
                default: begin
                    imem_req_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign rf_ra1     = instr_q[4:0];
    assign rf_ra2     = instr_q[9:5];
    assign rf_we      = rf_we_q;
    assign rf_wa      = rf_wa_q;
    assign rf_wd      = rf_wd_q;
    assign alu_op     = instr_q[30:26];
    assign alu_a      = opb_q;
    assign alu_b      = opa_q;
    assign mul_start  = mul_start_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = opb_q;
    assign illegal    = illegal_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer
// Program events are queued up front; a negedge monitor pops and compares them.
module tb_instr_sequencer;

    localparam int PC_W    = 8;
    localparam int K_FETCH = 0;
    localparam int K_RF    = 1;
    localparam int K_ST    = 2;
    localparam int K_LD    = 3;
    localparam int K_ILL   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_data;
    logic [4:0]      rf_ra1, rf_ra2;
    logic [15:0]     rf_rd1, rf_rd2;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [15:0]     rf_wd;
    logic [4:0]      alu_op;
    logic [15:0]     alu_a, alu_b;
    logic [15:0]     alu_y, alu_hi;
    logic            mul_start;
    logic            mul_done;
    logic [15:0]     mul_lo, mul_hi;
    logic            dmem_req, dmem_we;
    logic [7:0]      dmem_addr;
    logic [15:0]     dmem_wdata, dmem_rdata;
    logic            dmem_ack;
    logic            illegal;
    logic            busy;

    always #5 clk = ~clk;

    instr_sequencer #(.PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_hi(alu_hi),
        .mul_start(mul_start), .mul_done(mul_done), .mul_lo(mul_lo), .mul_hi(mul_hi),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .illegal(illegal), .busy(busy)
    );

    // environment models
    logic [31:0] rom [256];
    logic [15:0] regs [32];
    logic [15:0] dmem [256];
    int          dcnt = 0;
    int          mcnt = 0;
    logic [31:0] prod;
    logic [16:0] alu_t;

    assign imem_ack   = imem_req;
    assign imem_data  = rom[imem_addr];
    assign rf_rd1     = regs[rf_ra1];
    assign rf_rd2     = regs[rf_ra2];
    assign dmem_ack   = dmem_req && (dcnt == 2);
    assign dmem_rdata = dmem[dmem_addr];
    assign prod       = {16'b0, alu_a} * {16'b0, alu_b};
    assign mul_lo     = prod[15:0];
    assign mul_hi     = prod[31:16];
    assign alu_y      = alu_t[15:0];
    assign alu_hi     = {15'b0, alu_t[16]};

    always_comb begin
        alu_t = '0;
        case (alu_op)
            5'h04:   alu_t = {1'b0, alu_a} + {1'b0, alu_b};
            5'h05:   alu_t = {1'b0, alu_a} - {1'b0, alu_b};
            5'h08:   alu_t = {1'b0, alu_a & alu_b};
            5'h09:   alu_t = {1'b0, alu_a | alu_b};
            5'h0A:   alu_t = {1'b0, alu_a ^ alu_b};
            default: alu_t = '0;
        endcase
    end

    always @(posedge clk) begin
        if (rf_we) regs[rf_wa] <= rf_wd;
        if (dmem_req && dmem_we && dmem_ack) dmem[dmem_addr] <= dmem_wdata;
        if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
        else dcnt <= 0;
        if (mul_start) begin
            mcnt     <= 3;
            mul_done <= 1'b0;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mul_done <= 1'b1;
        end
    end

    // scoreboard
    typedef struct {
        int kind;
        int a;
        int d;
        int n;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic push(input int k, input int a, input int d, input int n);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        e.n    = n;
        exp_q.push_back(e);
    endtask

    function automatic bit pop(input string name, output ev_t e);
        e = '{default: 0};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got unexpected event expected none", name);
            return 1'b0;
        end
        e = exp_q.pop_front();
        return 1'b1;
    endfunction

    function automatic int lat(input int a);
        case (a)
            0, 1, 2, 5, 8: return 4;
            3, 9:          return 5;
            4:             return 9;
            6:             return 6;
            7:             return 7;
            default:       return 2;
        endcase
    endfunction

    task automatic expect_instr(input int a, input int n_prev);
        push(K_FETCH, a, 0, n_prev);
        case (a)
            0: push(K_RF, 3, 16'h1234, 0);
            1: push(K_RF, 1, 16'hFFFF, 0);
            2: push(K_RF, 2, 16'h0001, 0);
            3: begin push(K_RF, 6, 16'h0000, 0); push(K_RF, 5, 16'h0001, 0); end
            4: begin push(K_RF, 9, 16'hEDCC, 0); push(K_RF, 8, 16'h1233, 0); end
            5: push(K_RF, 10, 16'hBEEF, 0);
            6: push(K_ST, 8'h40, 16'hBEEF, 3);
            7: begin push(K_LD, 8'h40, 0, 3); push(K_RF, 11, 16'hBEEF, 0); end
            8: push(K_RF, 12, 16'hACDB, 0);
            9: begin push(K_RF, 14, 16'hEDCD, 0); push(K_RF, 13, 16'h0001, 0); end
            default: push(K_ILL, 0, 0, 0);
        endcase
    endtask

    int         cyc = 0;
    int         last_fetch = 0;
    bit         in_req = 1'b0;
    logic [7:0] req_addr;
    int         req_cnt = 0;

    always @(negedge clk) begin
        ev_t e;
        if (!mon_en) begin
            in_req = 1'b0;
        end else begin
            cyc++;
            if (imem_req && imem_ack) begin
                if (pop("fetch", e)) begin
                    chk("fetch_kind", e.kind, K_FETCH);
                    chk("fetch_addr", {24'b0, imem_addr}, e.a);
                    if (e.n >= 0) chk("fetch_latency", cyc - last_fetch, e.n);
                end
                last_fetch = cyc;
            end
            if (rf_we) begin
                if (pop("rf_write", e)) begin
                    chk("rf_kind", e.kind, K_RF);
                    chk("rf_wa", {27'b0, rf_wa}, e.a);
                    chk("rf_wd", {16'b0, rf_wd}, e.d);
                end
            end
            if (dmem_req) begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    req_addr = dmem_addr;
                    req_cnt  = 0;
                end
                req_cnt++;
                if (dmem_ack) begin
                    in_req = 1'b0;
                    if (pop("dmem", e)) begin
                        chk("dmem_kind", e.kind, dmem_we ? K_ST : K_LD);
                        chk("dmem_addr", {24'b0, dmem_addr}, e.a);
                        chk("dmem_addr_stable", {24'b0, req_addr}, e.a);
                        chk("dmem_req_cycles", req_cnt, e.n);
                        if (dmem_we) chk("dmem_wdata", {16'b0, dmem_wdata}, e.d);
                    end
                end
            end
            if (illegal) begin
                if (pop("illegal", e)) chk("illegal_kind", e.kind, K_ILL);
            end
        end
    end

    initial begin
        int  prev;
        bit  ok;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom[i]  = 32'h4400_0000;
            dmem[i] = '0;
        end
        for (int i = 0; i < 32; i++) regs[i] = '0;
        rom[0] = 32'h0060_1234;
        rom[1] = 32'h0020_FFFF;
        rom[2] = 32'h0040_0001;
        rom[3] = 32'h10A6_0022;
        rom[4] = 32'h1D09_0061;
        rom[5] = 32'h0140_BEEF;
        rom[6] = 32'h0D00_0140;
        rom[7] = 32'h0960_0040;
        rom[8] = 32'h280C_0143;
        rom[9] = 32'h15AE_0043;

        prev = -1;
        for (int a = 0; a < 256; a++) begin
            expect_instr(a, prev);
            prev = lat(a);
        end
        for (int a = 0; a < 6; a++) begin
            expect_instr(a, prev);
            prev = lat(a);
        end
        push(K_FETCH, 6, 0, prev);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req", imem_req, 1);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_wa_wd", {rf_wa, rf_wd}, 0);
        chk("rst_dmem_req_we", {dmem_req, dmem_we}, 0);
        chk("rst_dmem_addr_wdata", {dmem_addr, dmem_wdata}, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        chk("rst_ra_op", {rf_ra1, rf_ra2, alu_op}, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && dmem_req) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_second_store", ok, 1);

        rst_n  = 1'b0;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_dmem_req", dmem_req, 0);
        chk("midrst_dmem_we", dmem_we, 0);
        chk("midrst_imem_req", imem_req, 1);
        chk("midrst_imem_addr", imem_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rf_we", rf_we, 0);
        chk("midrst_no_store", dmem[8'h40], 16'hBEEF);
        @(posedge clk);
        #1;
        chk("midrst_rf_we_hold", rf_we, 0);

        push(K_FETCH, 0, 0, -1);
        push(K_RF, 3, 16'h1234, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("post_reset_drain", ok, 1);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
